// File: rtl/ps2_kb_rx.sv
// PS/2 keyboard receiver: conditions the raw pins, frames 11-bit PS/2 frames and
// folds E0/F0 prefix bytes into flag bits of the following scancode word.
module ps2_kb_rx #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 25000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [15:0] kb_data,
  output logic        kb_ready,
  output logic        kb_err,
  output logic        kb_busy
);

  localparam logic [7:0]  FLT_LAST = 8'(FILTER_LEN - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

  logic [1:0] pin_raw;
  logic [1:0] filt;
  assign pin_raw = {ps2_data, ps2_clk};

  // Per line: 2-flop synchroniser, then a run-length filter that only flips
  // after FILTER_LEN consecutive samples disagree with the current value.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_line
      logic       s1_reg, s2_reg, f_reg;
      logic [7:0] cnt_reg;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          s1_reg  <= 1'b1;
          s2_reg  <= 1'b1;
          f_reg   <= 1'b1;
          cnt_reg <= 8'd0;
        end else begin
          s1_reg <= pin_raw[gi];
          s2_reg <= s1_reg;
          if (s2_reg == f_reg) begin
            cnt_reg <= 8'd0;
          end else if (cnt_reg == FLT_LAST) begin
            f_reg   <= s2_reg;
            cnt_reg <= 8'd0;
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end
      end
      assign filt[gi] = f_reg;
    end
  endgenerate

  logic clk_prev_reg;
  logic fall;
  logic data_f;
  assign data_f = filt[1];
  assign fall   = clk_prev_reg & ~filt[0];

  state_t      state_reg, state_next;
  logic [3:0]  bit_cnt_reg, bit_cnt_next;
  logic [7:0]  shift_reg, shift_next;
  logic        parity_reg, parity_next;
  logic [15:0] to_cnt_reg, to_cnt_next;
  logic        ext_reg, ext_next;
  logic        rel_reg, rel_next;
  logic [15:0] data_reg, data_next;
  logic        ready_reg, ready_next;
  logic        err_reg, err_next;
  logic        timeout;
  logic        frame_ok;

  assign timeout  = (state_reg == SHIFT) && !fall && (to_cnt_reg >= TO_LAST);
  assign frame_ok = (^shift_reg ^ parity_reg) & data_f;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      clk_prev_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      clk_prev_reg <= filt[0];
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (fall && !data_f) state_next = SHIFT;
      SHIFT: begin
        if (fall && bit_cnt_reg == 4'd9) state_next = CHECK;
        else if (timeout)                state_next = IDLE;
      end
      CHECK:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The verdict is registered on the stop-bit edge so the strobes line up
  // with the single CHECK cycle.
  always_comb begin
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    parity_next  = parity_reg;
    to_cnt_next  = to_cnt_reg;
    ext_next     = ext_reg;
    rel_next     = rel_reg;
    data_next    = data_reg;
    ready_next   = 1'b0;
    err_next     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (fall && !data_f) begin
          bit_cnt_next = 4'd0;
          to_cnt_next  = 16'd0;
        end
      end
      SHIFT: begin
        if (fall) begin
          to_cnt_next = 16'd0;
          if (bit_cnt_reg < 4'd8) shift_next = {data_f, shift_reg[7:1]};
          if (bit_cnt_reg == 4'd8) parity_next = data_f;
          if (bit_cnt_reg == 4'd9) begin
            bit_cnt_next = 4'd0;
            if (!frame_ok) begin
              err_next = 1'b1;
              ext_next = 1'b0;
              rel_next = 1'b0;
            end else if (shift_reg == 8'hE0) begin
              ext_next = 1'b1;
            end else if (shift_reg == 8'hF0) begin
              rel_next = 1'b1;
            end else begin
              data_next  = {6'b0, ext_reg, rel_reg, shift_reg};
              ready_next = 1'b1;
              ext_next   = 1'b0;
              rel_next   = 1'b0;
            end
          end else begin
            bit_cnt_next = bit_cnt_reg + 4'd1;
          end
        end else if (timeout) begin
          err_next     = 1'b1;
          bit_cnt_next = 4'd0;
          to_cnt_next  = 16'd0;
          ext_next     = 1'b0;
          rel_next     = 1'b0;
        end else if (to_cnt_reg != 16'hFFFF) begin
          to_cnt_next = to_cnt_reg + 16'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_reg <= 4'd0;
      shift_reg   <= 8'd0;
      parity_reg  <= 1'b0;
      to_cnt_reg  <= 16'd0;
      ext_reg     <= 1'b0;
      rel_reg     <= 1'b0;
      data_reg    <= 16'd0;
      ready_reg   <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
      parity_reg  <= parity_next;
      to_cnt_reg  <= to_cnt_next;
      ext_reg     <= ext_next;
      rel_reg     <= rel_next;
      data_reg    <= data_next;
      ready_reg   <= ready_next;
      err_reg     <= err_next;
    end
  end

  assign kb_data  = data_reg;
  assign kb_ready = ready_reg;
  assign kb_err   = err_reg;
  assign kb_busy  = (state_reg != IDLE);

endmodule

// File: tb/tb_ps2_kb_rx.sv
// Directed bench for ps2_kb_rx: plain, prefixed, parity error, timeout,
// glitch and mid-frame reset scenarios with hand-computed key words.
module tb_ps2_kb_rx;
  localparam int FLT  = 8;
  localparam int TO   = 300;
  localparam int HALF = 40;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        ps2_clk;
  logic        ps2_data;
  logic [15:0] kb_data;
  logic        kb_ready;
  logic        kb_err;
  logic        kb_busy;

  int tests  = 0;
  int fails  = 0;
  int cyc    = 0;
  int ready_cnt, err_cnt, both_cnt;
  int err_cyc, fall_cyc;
  logic [15:0] last_data;

  ps2_kb_rx #(.FILTER_LEN(FLT), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .kb_data(kb_data), .kb_ready(kb_ready), .kb_err(kb_err), .kb_busy(kb_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (kb_ready) begin
      ready_cnt = ready_cnt + 1;
      last_data = kb_data;
    end
    if (kb_err) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc;
    end
    if (kb_ready && kb_err) both_cnt = both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests = tests + 1;
    if (got !== exp) begin
      fails = fails + 1;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic clear_counts();
    ready_cnt = 0;
    err_cnt   = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  // Sends the first nbits of a frame; glitch adds a 3-cycle low pulse on
  // ps2_clk in the high phase of data bit 2.
  task automatic send_frame(input logic [7:0] b, input logic bad_par,
                            input int nbits, input logic glitch);
    logic [10:0] fr;
    fr = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk); #1 ps2_data = fr[i];
      idle(HALF / 2);
      if (glitch && i == 3) begin
        #1 ps2_clk = 1'b0;
        idle(3);
        #1 ps2_clk = 1'b1;
      end
      idle(HALF / 2);
      #1 ps2_clk = 1'b0;
      fall_cyc = cyc;
      idle(HALF);
      #1 ps2_clk = 1'b1;
    end
    #1 ps2_data = 1'b1;
  endtask

  task automatic key(input logic [7:0] b);
    send_frame(b, 1'b0, 11, 1'b0);
    idle(60);
  endtask

  initial begin
    ps2_clk   = 1'b1;
    ps2_data  = 1'b1;
    reset_n   = 1'b0;
    both_cnt  = 0;
    err_cyc   = 0;
    fall_cyc  = 0;
    last_data = 16'h0;
    clear_counts();
    idle(5);
    #1;
    chk("rst_data", 32'(kb_data), 32'h0);
    chk("rst_ready", 32'(kb_ready), 32'h0);
    chk("rst_err", 32'(kb_err), 32'h0);
    chk("rst_busy", 32'(kb_busy), 32'h0);
    @(posedge clk); #1 reset_n = 1'b1;
    idle(30);

    // plain make code
    clear_counts();
    key(8'h1C);
    chk("plain_ready_cnt", 32'(ready_cnt), 32'd1);
    chk("plain_data", 32'(last_data), 32'h001C);
    chk("plain_err_cnt", 32'(err_cnt), 32'd0);
    chk("plain_busy", 32'(kb_busy), 32'h0);

    // E0 F0 75 then plain 75
    clear_counts();
    key(8'hE0);
    chk("e0_no_ready", 32'(ready_cnt), 32'd0);
    key(8'hF0);
    chk("f0_no_ready", 32'(ready_cnt), 32'd0);
    key(8'h75);
    chk("ext_rel_ready_cnt", 32'(ready_cnt), 32'd1);
    chk("ext_rel_data", 32'(last_data), 32'h0375);
    key(8'h75);
    chk("after_prefix_data", 32'(last_data), 32'h0075);
    chk("prefix_err_cnt", 32'(err_cnt), 32'd0);

    // parity error, then a released key
    clear_counts();
    send_frame(8'h1C, 1'b1, 11, 1'b0);
    idle(60);
    chk("par_err_cnt", 32'(err_cnt), 32'd1);
    chk("par_no_ready", 32'(ready_cnt), 32'd0);
    key(8'hF0);
    key(8'h1C);
    chk("par_then_rel_data", 32'(last_data), 32'h011C);

    // timeout after 4 bits
    clear_counts();
    send_frame(8'h29, 1'b0, 4, 1'b0);
    chk("to_busy_mid", 32'(kb_busy), 32'h1);
    idle(TO + 60);
    chk("to_err_cnt", 32'(err_cnt), 32'd1);
    chk("to_latency_lo", 32'(err_cyc - fall_cyc >= TO + FLT), 32'h1);
    chk("to_latency_hi", 32'(err_cyc - fall_cyc <= TO + FLT + 6), 32'h1);
    chk("to_busy_after", 32'(kb_busy), 32'h0);
    key(8'h29);
    chk("to_then_data", 32'(last_data), 32'h0029);
    chk("to_ready_cnt", 32'(ready_cnt), 32'd1);

    // glitches idle and mid-frame
    clear_counts();
    @(posedge clk); #1 ps2_clk = 1'b0;
    idle(3);
    #1 ps2_clk = 1'b1;
    idle(30);
    chk("glitch_idle_busy", 32'(kb_busy), 32'h0);
    send_frame(8'h4B, 1'b0, 11, 1'b1);
    idle(60);
    chk("glitch_data", 32'(last_data), 32'h004B);
    chk("glitch_ready_cnt", 32'(ready_cnt), 32'd1);
    chk("glitch_err_cnt", 32'(err_cnt), 32'd0);

    // asynchronous reset during bit 5, then a clean frame
    clear_counts();
    send_frame(8'h5A, 1'b0, 6, 1'b0);
    chk("rstmid_busy_before", 32'(kb_busy), 32'h1);
    #3 reset_n = 1'b0;
    #1;
    chk("rstmid_data", 32'(kb_data), 32'h0);
    chk("rstmid_busy", 32'(kb_busy), 32'h0);
    chk("rstmid_ready_err", 32'({kb_ready, kb_err}), 32'h0);
    idle(4);
    #1 reset_n = 1'b1;
    idle(30);
    key(8'h5A);
    chk("rstmid_then_data", 32'(last_data), 32'h005A);
    chk("rstmid_ready_cnt", 32'(ready_cnt), 32'd1);

    chk("ready_err_overlap", 32'(both_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
